fifo_drain_arbiter: RTL
=======================

# fifo_drain_arbiter

Round-robin read scheduler that shares one output stream between NCH first-word-fall-through (FWFT) channel FIFOs in the digitizer readout path. It pops words from the granted channel in bursts of up to BURST words and presents them on a registered valid/ready output, tagged with the source channel. It sits between the per-channel FWFT FIFO read ports and the single packetizer/transport interface.

## Interface
Parameters:
- NCH, 4: number of channel FIFOs; range 2..16.
- DWIDTH, 16: data word width.
- BURST, 8: maximum words per grant; range 1..256.
- CHW, 2: channel index width; must equal ceil(log2(NCH)).

Ports:
- clk  in  1  single clock for all logic and for every FIFO read side.
- aresetn  in  1  asynchronous, active-low reset.
- ch_enable  in  NCH  per-channel enable; a channel whose bit is 0 is never granted.
- ch_empty  in  NCH  FWFT empty per channel; 0 means ch_dout holds a valid head word.
- ch_dout  in  NCH*DWIDTH  FWFT head words; channel i is at bits [i*DWIDTH +: DWIDTH].
- ch_rd_en  out  NCH  active-high pop strobes; at most one bit is high in any cycle.
- out_data  out  DWIDTH (+CHW with macro)  output word.
- out_ch  out  CHW  source channel of out_data.
- out_last  out  1  marks the BURST-th word of a full burst.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accept.
- underrun  out  1  one-cycle pulse when a burst ends early because the granted channel went empty.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM has three states: IDLE, ARB, DRAIN.
- IDLE: when the request vector req = ~ch_empty & ch_enable is nonzero, go to ARB.
- ARB: select the first requesting channel at or after rr_ptr, wrapping modulo NCH. Register it in gnt, clear word count cnt, go to DRAIN. If req has become 0, return to IDLE.
- DRAIN: load = (!out_valid | out_ready) & !ch_empty[gnt] & ch_enable[gnt].
  - ch_rd_en[gnt] = load. All other ch_rd_en bits are 0. The pop is combinational from out_ready.
  - On load: out_data <= ch_dout[gnt]; out_ch <= gnt; out_valid <= 1; cnt <= cnt+1; out_last <= (cnt == BURST-1).
  - When out_valid=1 and out_ready=1 with no load in the same cycle: out_valid <= 0.
- Burst end. The last pop of a burst is the cycle where load=1 and cnt==BURST-1.
  - Full burst: on that cycle, rr_ptr <= (gnt+1) mod NCH, then go to ARB.
  - Underrun: ch_empty[gnt]=1 while cnt<BURST and ch_enable[gnt]=1. Pulse underrun, set rr_ptr <= gnt+1, go to ARB. The last word already in flight carries no out_last.
  - Disable: ch_enable[gnt] drops mid-burst. Terminate the same way as underrun, but do not pulse underrun.
- rr_ptr wraps from NCH-1 to 0.
- cnt is ceil(log2(BURST+1)) bits wide and never exceeds BURST.
- Simultaneous out_ready and load in one cycle: the output register is replaced by the new word, with no bubble.
- The output register holds its contents in ARB and IDLE until accepted. Arbitration never stalls on a pending output word.

## Timing
- Reset values: out_valid=0, out_last=0, out_data=0, out_ch=0, ch_rd_en=0, underrun=0, busy=0, state=IDLE, rr_ptr=0, gnt=0, cnt=0.
- Latency: if ch_empty[i] falls at edge T in IDLE, ARB occupies T+1, the first pop is in cycle T+2, and out_valid=1 after edge T+3.
- Throughput: 1 word/cycle within a burst while out_ready=1.
- Burst-to-burst gap: one ARB cycle with no pop.
- out_* signals are stable while out_valid=1 and out_ready=0.
- Reset asserted mid-burst: all registers clear immediately and ch_rd_en goes low asynchronously. The word in the output register is discarded.

## Configuration
- FIFO_ARB_CHTAG_EN defined: out_data is DWIDTH+CHW wide, with the channel index in the upper CHW bits and the word in the lower DWIDTH bits. out_ch is still driven.
- FIFO_ARB_CHTAG_EN undefined: out_data is DWIDTH wide and carries the word only.

## Test plan
- Single channel: ch1 holds 8 words 0x100..0x107, out_ready=1, BURST=8. Expect 8 consecutive words with out_ch=1, out_last on 0x107, first out_valid 3 cycles after ch_empty falls.
- Round-robin: all 4 channels hold 16 words each. Expect grant order 0,1,2,3,0,1,2,3, each burst 8 words with out_last, one idle cycle between bursts.
- Underrun: ch2 holds 3 words. Expect 3 words, no out_last, a one-cycle underrun pulse, and the next grant going to ch3 when it requests.
- Backpressure: out_ready toggles 1,0,0,1 during a burst. Expect no pop while out_valid=1 and out_ready=0, no lost or duplicated word, and out_data held stable.
- Enable and reset: ch_enable[0]=0 with ch0 non-empty, so ch0 is never granted. Assert aresetn=0 at word 4 of a ch1 burst: out_valid and ch_rd_en go to 0 at once; after release, grant restarts from ch0 priority (rr_ptr=0).

Source files
------------

// File: rtl/fifo_drain_arbiter.sv
// fifo_drain_arbiter
//   Round-robin read scheduler sharing one registered valid/ready output stream
//   between NCH first-word-fall-through channel FIFOs. The granted channel is
//   drained in bursts of up to BURST words. Each output word is tagged with its
//   source channel.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no enabled channel has data; output register may still hold a word
//   ARB   | pick first requester at/after rr_ptr, latch gnt, clear cnt
//   DRAIN | pop granted channel into the output register until burst end
//
// Ports
//   clk        single clock (also the FIFO read-side clock)
//   aresetn    asynchronous active-low reset
//   ch_enable  per-channel enable; disabled channels are never granted
//   ch_empty   FWFT empty flags, 0 = ch_dout holds a valid head word
//   ch_dout    FWFT head words, channel i at [i*DWIDTH +: DWIDTH]
//   ch_rd_en   pop strobes, at most one high, combinational from out_ready
//   out_data   output word (channel index prepended with FIFO_ARB_CHTAG_EN)
//   out_ch     source channel of out_data
//   out_last   marks the BURST-th word of a full burst
//   out_valid  output word valid
//   out_ready  downstream accept
//   underrun   one-cycle pulse when a burst ends because the channel ran dry
//   busy       high whenever the FSM is not in IDLE
//
// Build option
//   FIFO_ARB_CHTAG_EN : out_data becomes DWIDTH+CHW wide, {channel, word}.

module fifo_drain_arbiter #(
  parameter int NCH    = 4,
  parameter int DWIDTH = 16,
  parameter int BURST  = 8,
  parameter int CHW    = 2
) (
  input  logic                    clk,
  input  logic                    aresetn,
  input  logic [NCH-1:0]          ch_enable,
  input  logic [NCH-1:0]          ch_empty,
  input  logic [NCH*DWIDTH-1:0]   ch_dout,
  output logic [NCH-1:0]          ch_rd_en,
`ifdef FIFO_ARB_CHTAG_EN
  output logic [DWIDTH+CHW-1:0]   out_data,
`else
  output logic [DWIDTH-1:0]       out_data,
`endif
  output logic [CHW-1:0]          out_ch,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    underrun,
  output logic                    busy
);

  localparam int CNTW = $clog2(BURST + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(BURST - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CHW-1:0]    rr_ptr;
  logic [CHW-1:0]    gnt;
  logic [CHW-1:0]    gnt_inc;
  logic [CHW-1:0]    arb_sel;
  logic [CHW-1:0]    arb_idx;
  logic [CNTW-1:0]   cnt;
  logic [NCH-1:0]    req;
  logic              gnt_empty;
  logic              gnt_en;
  logic [DWIDTH-1:0] gnt_word;
  logic              load;
  logic              burst_end;
  logic              underrun_evt;

  assign req       = ~ch_empty & ch_enable;
  assign gnt_empty = ch_empty[gnt];
  assign gnt_en    = ch_enable[gnt];
  assign gnt_word  = ch_dout[gnt*DWIDTH +: DWIDTH];
  assign gnt_inc   = (gnt == CHW'(NCH - 1)) ? '0 : gnt + 1'b1;
  assign busy      = (state != IDLE);

  // Walk offsets from the far end so the lowest offset from rr_ptr wins.
  always_comb begin
    arb_sel = rr_ptr;
    arb_idx = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      arb_idx = CHW'((int'(rr_ptr) + k) % NCH);
      if (req[arb_idx]) arb_sel = arb_idx;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    load         = 1'b0;
    burst_end    = 1'b0;
    underrun_evt = 1'b0;
    ch_rd_en     = '0;
    case (state)
      IDLE: begin
        if (|req) state_nxt = ARB;
      end
      ARB: begin
        state_nxt = (|req) ? DRAIN : IDLE;
      end
      DRAIN: begin
        // Pop only when the output register is free or being emptied now.
        load          = (!out_valid || out_ready) && !gnt_empty && gnt_en;
        ch_rd_en[gnt] = load;
        if (!gnt_en) begin
          burst_end = 1'b1;
        end else if (gnt_empty) begin
          burst_end    = 1'b1;
          underrun_evt = 1'b1;
        end else if (load && (cnt == CNT_LAST)) begin
          burst_end = 1'b1;
        end
        if (burst_end) state_nxt = ARB;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rr_ptr    <= '0;
      gnt       <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= underrun_evt;
      if (burst_end) rr_ptr <= gnt_inc;
      if ((state == ARB) && (|req)) begin
        gnt <= arb_sel;
        cnt <= '0;
      end
      if (load) begin
`ifdef FIFO_ARB_CHTAG_EN
        out_data <= {gnt, gnt_word};
`else
        out_data <= gnt_word;
`endif
        out_ch    <= gnt;
        out_valid <= 1'b1;
        out_last  <= (cnt == CNT_LAST);
        cnt       <= cnt + 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
